// File: rtl/spi_master_tx.sv
// SPI master transmitter: any CPOL/CPHA mode, MSB/LSB first, programmable SCLK divider and CS idle gap.
// Define SPI_RX_EN to capture spi_miso into rx_data; otherwise rx_data/rx_valid are tied to 0.
module spi_master_tx #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 1,
    parameter int CS_IDLE = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic                        cpol,
    input  logic                        cpha,
    input  logic                        lsb_first,
    output logic                        spi_cs,
    output logic                        spi_sclk,
    output logic                        spi_data,
    input  logic                        spi_miso,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    output logic                        busy,
    output logic [$clog2(DATA_W+1)-1:0] bit_cnt,
    output logic [1:0]                  fsm_state
);

    localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(2 * DATA_W + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_IDLE - 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [TW-1:0]     tog_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic              cpol_q, cpha_q, lsb_q;
    logic              accept, div_done, gap_done, last_tog, leading;
    logic              sample_edge, drive_edge, cs_rise;

    // Handshake: a word transfers on a rising clk edge where tx_valid && tx_ready;
    // tx_ready is high only in IDLE, and tx_valid in any other state is ignored.
    assign accept    = tx_valid && tx_ready;
    assign tx_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    assign div_done = (cnt == DIV_LAST);
    assign gap_done = (cnt == GAP_LAST);
    assign last_tog = (tog_cnt == TOG_LAST);
    // tog_cnt holds toggles already made, so an even count means the next toggle is leading.
    assign leading  = ~tog_cnt[0];
    assign sample_edge = (state == SHIFT) && div_done && (cpha_q ? ~leading : leading);
    assign drive_edge  = (state == SHIFT) && div_done &&
                         (cpha_q ? (leading && (tog_cnt != '0)) : (~leading && ~last_tog));
    assign cs_rise     = (state == HOLD) && div_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (div_done && last_tog) state_nx = HOLD;
            HOLD:    if (div_done) state_nx = GAP;
            GAP:     if (gap_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            tog_cnt  <= '0;
            tx_sh    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            spi_sclk <= 1'b0;
            spi_data <= 1'b0;
            spi_cs   <= 1'b1;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpol_q   <= cpol;
                    cpha_q   <= cpha;
                    lsb_q    <= lsb_first;
                    spi_sclk <= cpol;
                    cnt      <= '0;
                    tog_cnt  <= '0;
                    if (accept) begin
                        tx_sh    <= tx_data;
                        spi_cs   <= 1'b0;
                        spi_data <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                    end
                end
                SHIFT: begin
                    if (div_done) begin
                        cnt      <= '0;
                        tog_cnt  <= tog_cnt + 1'b1;
                        spi_sclk <= ~spi_sclk;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    if (drive_edge) begin
                        if (lsb_q) begin
                            tx_sh    <= tx_sh >> 1;
                            spi_data <= tx_sh[1];
                        end else begin
                            tx_sh    <= tx_sh << 1;
                            spi_data <= tx_sh[DATA_W-2];
                        end
                    end
                    if (sample_edge) bit_cnt <= bit_cnt + 1'b1;
                end
                HOLD: begin
                    if (div_done) begin
                        cnt    <= '0;
                        spi_cs <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

`ifdef SPI_RX_EN
    logic [DATA_W-1:0] rx_sh;

    // Received bits shift in the same direction as transmit so rx_data matches bit order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (sample_edge)
                rx_sh <= lsb_q ? {spi_miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], spi_miso};
            if (cs_rise) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign rx_data     = '0;
    assign rx_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: default-parameter instance plus a DATA_W=8, CLK_DIV=3 instance,
// checked against a bit-order model of each frame and the frame timing formulas.
module tb_spi_master_tx;

  localparam int DW = 16;
  localparam int CD = 1;
  localparam int CI = 2;
  localparam int CS_LOW = (2 * DW + 1) * CD;
  localparam int ACC2ACC = 1 + CS_LOW + CI;
`ifdef SPI_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready, cpol, cpha, lsb_first;
  logic          spi_cs, spi_sclk, spi_data, spi_miso;
  logic [DW-1:0] rx_data;
  logic          rx_valid, busy;
  logic [4:0]    bit_cnt;
  logic [1:0]    fsm_state;
  logic          loop_en = 1'b1;
  logic          miso_bit = 1'b0;

  assign spi_miso = loop_en ? spi_data : miso_bit;

  spi_master_tx #(.DATA_W(DW), .CLK_DIV(CD), .CS_IDLE(CI)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
    .spi_data(spi_data), .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .bit_cnt(bit_cnt), .fsm_state(fsm_state)
  );

  // ---------------- 8-bit, divide-by-3 instance ----------------
  logic [7:0] tx8, rx8;
  logic       valid8, ready8, cpol8, cpha8, lsb8, cs8, sclk8, data8, rxv8, busy8;
  logic [3:0] bc8;
  logic [1:0] st8;

  spi_master_tx #(.DATA_W(8), .CLK_DIV(3), .CS_IDLE(2)) dut8 (
    .clk(clk), .rst(rst), .tx_data(tx8), .tx_valid(valid8), .tx_ready(ready8),
    .cpol(cpol8), .cpha(cpha8), .lsb_first(lsb8), .spi_cs(cs8), .spi_sclk(sclk8),
    .spi_data(data8), .spi_miso(data8), .rx_data(rx8), .rx_valid(rxv8),
    .busy(busy8), .bit_cnt(bc8), .fsm_state(st8)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  logic       samp_q[$];
  logic       miso_q[$];
  int         acc_q[$];
  int         bc_q[$];
  int         cycle = 0, cs_low_cnt = 0, gap_hi_cnt = 0, rxv_cnt = 0;
  logic       samp_level = 1'b1;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0;

  logic       samp8_q[$];
  int         cs8_low = 0, tog8 = 0, hp8 = 0, hp8_bad = 0;
  logic       prev_cs8 = 1'b1, prev_sclk8 = 1'b0;

  // Monitor of the default instance, sampling away from the active edge.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      if (tx_valid && tx_ready) acc_q.push_back(cycle);
      if (!spi_cs) cs_low_cnt++;
      if (spi_cs && busy) gap_hi_cnt++;
      if (spi_cs && !prev_cs) bc_q.push_back(int'(bit_cnt));
      if (!spi_cs && (spi_sclk != prev_sclk) && (spi_sclk == samp_level)) begin
        samp_q.push_back(spi_data);
        miso_q.push_back(spi_miso);
        miso_bit = 1'($urandom_range(0, 1));
      end
      if (rx_valid) rxv_cnt++;
    end
    prev_cs   = spi_cs;
    prev_sclk = spi_sclk;
  end

  // Monitor of the 8-bit instance: half-period lengths, toggles and rising-edge data.
  always @(negedge clk) begin
    if (rst && !cs8) begin
      cs8_low++;
      if (prev_cs8) begin
        hp8 = 0;
      end else begin
        hp8++;
        if (sclk8 != prev_sclk8) begin
          tog8++;
          if (hp8 != 3) hp8_bad++;
          hp8 = 0;
          if (sclk8) samp8_q.push_back(data8);
        end
      end
    end
    prev_cs8   = cs8;
    prev_sclk8 = sclk8;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the bit sent at the k-th sample edge.
  task automatic expect_word(input logic [DW-1:0] w, input logic lsb);
    for (int k = 0; k < DW; k++) exp_q.push_back(lsb ? w[k] : w[DW-1-k]);
  endtask

  function automatic logic [63:0] pack_exp();
    logic [63:0] v = '0;
    foreach (exp_q[i]) v = {v[62:0], exp_q[i]};
    return v;
  endfunction

  function automatic logic [63:0] pack_samp(input int base);
    logic [63:0] v = '0;
    for (int i = base; i < samp_q.size(); i++) v = {v[62:0], samp_q[i]};
    return v;
  endfunction

  function automatic logic [63:0] pack8(input int base);
    logic [63:0] v = '0;
    for (int i = base; i < samp8_q.size(); i++) v = {v[62:0], samp8_q[i]};
    return v;
  endfunction

  // Reference receive word: bit k lands at [DW-1-k] (MSB first) or [k] (LSB first).
  function automatic logic [DW-1:0] rx_model(input int base, input logic lsb);
    logic [DW-1:0] v = '0;
    for (int k = 0; k < DW; k++) begin
      if (base + k < miso_q.size()) begin
        if (lsb) v[k] = miso_q[base + k];
        else     v[DW-1-k] = miso_q[base + k];
      end
    end
    return v;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_done"}, busy, 1'b0);
  endtask

  task automatic run_frame(input string tag, input logic [DW-1:0] w,
                           input logic p, input logic h, input logic l, input logic loop);
    int sb, mb, cb, rb, bb;
    logic [DW-1:0] exp_rx;
    cpol = p; cpha = h; lsb_first = l; loop_en = loop; samp_level = (p == h);
    tick(2);
    check({tag, "_sclk_idle"}, spi_sclk, p);
    sb = samp_q.size(); mb = miso_q.size(); cb = cs_low_cnt; rb = rxv_cnt; bb = bc_q.size();
    exp_q.delete();
    expect_word(w, l);
    tx_data = w; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    check({tag, "_cs_fall"}, {spi_cs, tx_ready, busy}, 3'b001);
    wait_idle(tag, 200);
    exp_rx = loop ? w : rx_model(mb, l);
    check({tag, "_nbits"}, samp_q.size() - sb, DW);
    check({tag, "_mosi"}, pack_samp(sb), pack_exp());
    check({tag, "_cs_low"}, cs_low_cnt - cb, CS_LOW);
    check({tag, "_bitcnt_top"}, (bc_q.size() > bb) ? bc_q[bb] : -1, DW);
    check({tag, "_bitcnt_clr"}, bit_cnt, 0);
    check({tag, "_rxv"}, rxv_cnt - rb, RX_EN ? 1 : 0);
    check({tag, "_rx"}, rx_data, RX_EN ? exp_rx : '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int sb, cb, rb, ab, gb, n;
    rst = 1'b0;
    tx_data = '0; tx_valid = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    tx8 = '0; valid8 = 1'b0; cpol8 = 1'b0; cpha8 = 1'b0; lsb8 = 1'b0;
    tick(3);
    check("rst_cs", spi_cs, 1'b1);
    check("rst_sclk", spi_sclk, 1'b0);
    check("rst_data", spi_data, 1'b0);
    check("rst_ready_busy", {tx_ready, busy}, 2'b10);
    check("rst_bitcnt", bit_cnt, 0);
    check("rst_rx", {rx_data, rx_valid}, '0);
    check("rst_state", fsm_state, 0);
    check("rst8_cs_ready", {cs8, ready8, busy8}, 3'b110);
    rst = 1'b1;
    tick(2);

    run_frame("m0_a569", 16'hA569, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame("m3_2563", 16'h2563, 1'b1, 1'b1, 1'b1, 1'b1);

    // Back-to-back accepts with tx_valid held high.
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; loop_en = 1'b1; samp_level = 1'b1;
    tick(2);
    sb = samp_q.size(); cb = cs_low_cnt; rb = rxv_cnt; ab = acc_q.size(); gb = gap_hi_cnt;
    exp_q.delete();
    expect_word(16'h9B63, 1'b0);
    expect_word(16'h6A61, 1'b0);
    tx_data = 16'h9B63; tx_valid = 1'b1;
    tick(1);
    tx_data = 16'h6A61;
    n = 0;
    while ((acc_q.size() - ab) < 2 && n < 100) begin
      tick(1);
      n++;
    end
    tx_valid = 1'b0;
    check("b2b_accepts", acc_q.size() - ab, 2);
    check("b2b_acc2acc", (acc_q.size() - ab == 2) ? acc_q[ab+1] - acc_q[ab] : 0, ACC2ACC);
    check("b2b_cs_gap", gap_hi_cnt - gb, CI);
    wait_idle("b2b", 200);
    check("b2b_mosi", pack_samp(sb), pack_exp());
    check("b2b_cs_low", cs_low_cnt - cb, 2 * CS_LOW);
    check("b2b_rxv", rxv_cnt - rb, RX_EN ? 2 : 0);
    check("b2b_rx", rx_data, RX_EN ? 16'h6A61 : 16'h0);

    // Random words, modes and MISO data.
    for (int i = 0; i < 6; i++)
      run_frame($sformatf("rnd%0d", i), 16'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

    // Reset in the middle of a frame.
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; loop_en = 1'b1; samp_level = 1'b1;
    tick(2);
    rb = rxv_cnt;
    tx_data = 16'h7564; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(9);
    check("mid_busy", {busy, spi_cs}, 2'b10);
    #2 rst = 1'b0;
    #1;
    check("mrst_cs", spi_cs, 1'b1);
    check("mrst_sclk_data", {spi_sclk, spi_data}, 2'b00);
    check("mrst_ready_busy", {tx_ready, busy}, 2'b10);
    check("mrst_bitcnt", bit_cnt, 0);
    check("mrst_rx", {rx_data, rx_valid}, '0);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("mrst_no_rxv", rxv_cnt - rb, 0);
    run_frame("post_rst_a265", 16'hA265, 1'b0, 1'b0, 1'b0, 1'b1);

    // 8-bit instance, CLK_DIV=3, cpol changed mid-frame.
    tick(2);
    sb = samp8_q.size(); cb = cs8_low; ab = tog8; gb = hp8_bad;
    tx8 = 8'hA2; valid8 = 1'b1;
    tick(1);
    valid8 = 1'b0;
    tick(20);
    cpol8 = 1'b1;
    n = 0;
    while (busy8 && n < 300) begin
      tick(1);
      n++;
    end
    check("d8_done", busy8, 1'b0);
    check("d8_cs_low", cs8_low - cb, 51);
    check("d8_toggles", tog8 - ab, 16);
    check("d8_half_period_bad", hp8_bad - gb, 0);
    check("d8_nbits", samp8_q.size() - sb, 8);
    check("d8_mosi", pack8(sb), 64'hA2);
    check("d8_sclk_kept", sclk8, 1'b0);
    check("d8_rx", {rx8, bc8}, {(RX_EN ? 8'hA2 : 8'h00), 4'd0});
    tick(2);
    check("d8_sclk_new_idle", sclk8, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
